// File: rtl/capture_readout.sv
// Capture ring-buffer sink with oldest-first AXI-stream replay; CAPTURE_READOUT_TRIG_MARK_EN adds m_tuser trigger marking.
// First beat 2 cycles after dump, then 1 beat/cycle; m_tready stalls the output stage, abort drops m_tvalid at once.
module capture_readout #(
    parameter int size    = 32,
    parameter int saddr_w = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [size-1:0]    s_tdata,
    input  logic               s_tvalid,
    output logic               s_tready,
    input  logic               start,
    input  logic               done_in,
    input  logic               dump,
    input  logic               abort,
    input  logic [saddr_w-1:0] buffer_size,
    output logic [size-1:0]    m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast,
`ifdef CAPTURE_READOUT_TRIG_MARK_EN
    input  logic [saddr_w-1:0] trig_index,
    output logic [0:0]         m_tuser,
`endif
    output logic [saddr_w:0]   fill_count,
    output logic               wrapped,
    output logic               busy,
    output logic               holding
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_HOLD, S_DUMP} state_t;

    localparam int               DEPTH   = 1 << saddr_w;
    localparam logic [saddr_w:0] MAX_LEN = {1'b1, {saddr_w{1'b0}}};

    state_t             r_state;
    state_t             w_next;
    logic [size-1:0]    r_mem [DEPTH];
    logic [saddr_w:0]   r_len;
    logic [saddr_w:0]   r_fill;
    logic [saddr_w:0]   r_rd_left;
    logic [saddr_w-1:0] r_wr_ptr;
    logic [saddr_w-1:0] r_rd_ptr;
    logic               r_wrapped;
    logic               r_pend;
    logic               r_pend_last;
    logic               r_out_vld;
    logic               r_out_last;
    logic [size-1:0]    r_rd_data;
    logic [size-1:0]    r_out_dat;

    logic               w_wr;
    logic               w_wr_at_end;
    logic               w_restart;
    logic               w_acc;
    logic               w_load;
    logic               w_first_rd;
    logic               w_rd_en;
    logic               w_flush;
    logic [saddr_w-1:0] w_rd_addr;
    logic [saddr_w:0]   w_left_cur;

    function automatic logic [saddr_w-1:0] ring_inc(input logic [saddr_w-1:0] p,
                                                   input logic [saddr_w:0]   len);
        return ({1'b0, p} == len - 1'b1) ? '0 : p + 1'b1;
    endfunction

    assign s_tready   = (r_state == S_FILL);
    assign busy       = (r_state != S_IDLE);
    assign holding    = (r_state == S_HOLD);
    assign fill_count = r_fill;
    assign wrapped    = r_wrapped;
    assign m_tdata    = r_out_dat;
    assign m_tvalid   = r_out_vld & ~abort;
    assign m_tlast    = r_out_last & ~abort;

    assign w_restart   = ((r_state == S_IDLE) || (r_state == S_FILL)) && start && !abort;
    assign w_wr        = (r_state == S_FILL) && s_tvalid && !abort && !start;
    assign w_wr_at_end = ({1'b0, r_wr_ptr} == r_len - 1'b1);
    assign w_acc       = m_tvalid & m_tready;
    assign w_load      = r_pend & (~r_out_vld | w_acc);
    assign w_flush     = abort || (r_state == S_IDLE);
    assign w_first_rd  = (r_state == S_HOLD) && dump && !abort && (r_fill != '0);
    assign w_left_cur  = w_first_rd ? r_fill : r_rd_left;
    // The prefetch slot refills whenever it is empty or draining into the output register.
    assign w_rd_en     = w_first_rd ||
                         ((r_state == S_DUMP) && !abort && (r_rd_left != '0) && (!r_pend || w_load));
    assign w_rd_addr   = w_first_rd ? (r_wrapped ? r_wr_ptr : '0) : r_rd_ptr;

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next = S_FILL;
                S_FILL:  if (!start && done_in) w_next = S_HOLD;
                S_HOLD:  if (dump) w_next = (r_fill == '0) ? S_IDLE : S_DUMP;
                S_DUMP:  if (w_acc && r_out_last) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len     <= MAX_LEN;
            r_wr_ptr  <= '0;
            r_fill    <= '0;
            r_wrapped <= 1'b0;
        end else if (w_restart) begin
            r_len     <= (buffer_size == '0) ? MAX_LEN : {1'b0, buffer_size};
            r_wr_ptr  <= '0;
            r_fill    <= '0;
            r_wrapped <= 1'b0;
        end else if (w_wr) begin
            r_wr_ptr <= ring_inc(r_wr_ptr, r_len);
            if (w_wr_at_end)     r_wrapped <= 1'b1;
            if (r_fill != r_len) r_fill    <= r_fill + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr)    r_mem[r_wr_ptr] <= s_tdata;
        if (w_rd_en) r_rd_data       <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr    <= '0;
            r_rd_left   <= '0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_out_vld   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_dat   <= '0;
        end else if (w_flush) begin
            r_pend     <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_pend      <= 1'b1;
                r_pend_last <= (w_left_cur == (saddr_w+1)'(1));
                r_rd_ptr    <= ring_inc(w_rd_addr, r_len);
                r_rd_left   <= w_left_cur - 1'b1;
            end else if (w_load) begin
                r_pend <= 1'b0;
            end
            if (w_load) begin
                r_out_dat  <= r_rd_data;
                r_out_vld  <= 1'b1;
                r_out_last <= r_pend_last;
            end else if (w_acc) begin
                r_out_vld  <= 1'b0;
                r_out_last <= 1'b0;
            end
        end
    end

`ifdef CAPTURE_READOUT_TRIG_MARK_EN
    logic [saddr_w-1:0] r_trig;
    logic [saddr_w:0]   r_rd_ord;
    logic               r_pend_user;
    logic               r_out_user;
    logic [saddr_w-1:0] w_trig_cur;
    logic [saddr_w:0]   w_ord_cur;

    // Ordinals count issued reads, so the mark travels with its sample through prefetch and output.
    assign w_trig_cur = w_first_rd ? trig_index : r_trig;
    assign w_ord_cur  = w_first_rd ? '0 : r_rd_ord;
    assign m_tuser    = r_out_user;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_trig      <= '0;
            r_rd_ord    <= '0;
            r_pend_user <= 1'b0;
            r_out_user  <= 1'b0;
        end else begin
            if (w_first_rd) r_trig <= trig_index;
            if (w_flush) begin
                r_out_user <= 1'b0;
            end else begin
                if (w_rd_en) begin
                    r_rd_ord    <= w_ord_cur + 1'b1;
                    r_pend_user <= (w_ord_cur == {1'b0, w_trig_cur});
                end
                if (w_load)     r_out_user <= r_pend_user;
                else if (w_acc) r_out_user <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_capture_readout.sv
// Randomised bench for capture_readout against a queue model of the ring (newest L samples, oldest first).
module tb_capture_readout;
    localparam int SZ = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [SZ-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          start;
    logic          done_in;
    logic          dump;
    logic          abort;
    logic [AW-1:0] buffer_size;
    logic [SZ-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [AW:0]   fill_count;
    logic          wrapped;
    logic          busy;
    logic          holding;
`ifdef CAPTURE_READOUT_TRIG_MARK_EN
    logic [AW-1:0] trig_index;
    logic [0:0]    m_tuser;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_q[$];
    int          model_len;
    bit          model_wrapped;

    always #5 clk = ~clk;

    capture_readout #(.size(SZ), .saddr_w(AW)) dut (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .start(start), .done_in(done_in), .dump(dump), .abort(abort),
        .buffer_size(buffer_size),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
`ifdef CAPTURE_READOUT_TRIG_MARK_EN
        .trig_index(trig_index), .m_tuser(m_tuser),
`endif
        .fill_count(fill_count), .wrapped(wrapped), .busy(busy), .holding(holding)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int len_cfg, input int n, input bit det, input int base,
                        input bit gaps, input bit done_with_last);
        buffer_size = len_cfg[AW-1:0];
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("fill_rdy", s_tready, 1);
        check("fill_cnt0", fill_count, 0);
        model_q.delete();
        model_len = (len_cfg == 0) ? (1 << AW) : len_cfg;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(3) == 0) begin
                    s_tvalid = 1'b0;
                    cyc();
                end
            end
            s_tvalid = 1'b1;
            s_tdata  = det ? 32'(base + i) : $urandom;
            if (done_with_last && i == n - 1) done_in = 1'b1;
            cyc();
            model_q.push_back(s_tdata);
            if (model_q.size() > model_len) void'(model_q.pop_front());
        end
        s_tvalid = 1'b0;
        if (!(done_with_last && n > 0)) begin
            done_in = 1'b1;
            cyc();
        end
        done_in = 1'b0;
        model_wrapped = (n >= model_len);
        check("hold_state", holding, 1);
        check("hold_nrdy", s_tready, 0);
        check("hold_cnt", fill_count, model_q.size());
        check("hold_wrap", wrapped, model_wrapped);
    endtask

    task automatic dump_check(input int rdy_pct, input int trig);
        logic [31:0] exp[$];
        int          n;
        int          idx;
        int          first;
        int          cnt;
        bit          prev_stall;
        logic [31:0] prev_dat;
        logic        prev_last;
        exp        = model_q;
        n          = exp.size();
        idx        = 0;
        first      = -1;
        prev_stall = 1'b0;
        prev_dat   = '0;
        prev_last  = 1'b0;
`ifdef CAPTURE_READOUT_TRIG_MARK_EN
        trig_index = trig[AW-1:0];
`endif
        dump = 1'b1;
        cyc();
        dump = 1'b0;
        cnt  = 1;
        if (n == 0) begin
            check("empty_idle", busy, 0);
            repeat (4) begin
                check("empty_novld", m_tvalid, 0);
                cyc();
            end
            return;
        end
        while (idx < n && cnt < 400) begin
            m_tready = ($urandom_range(99) < rdy_pct);
            if (prev_stall)
                check("stall_stable", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_last, prev_dat});
            if (m_tvalid && first < 0) first = cnt;
            if (m_tvalid && m_tready) begin
                check("beat_data", m_tdata, exp[idx]);
                check("beat_last", m_tlast, idx == n - 1);
`ifdef CAPTURE_READOUT_TRIG_MARK_EN
                check("beat_user", m_tuser, idx == trig);
`endif
                idx++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_dat   = m_tdata;
            prev_last  = m_tlast;
            cyc();
            cnt++;
        end
        m_tready = 1'b0;
        check("beat_count", idx, n);
        check("first_lat", first, 2);
        check("end_idle", busy, 0);
        check("end_novld", m_tvalid, 0);
        check("keep_cnt", fill_count, n);
        check("keep_wrap", wrapped, model_wrapped);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hs;
        int cnt;
        reset = 1'b0; s_tdata = '0; s_tvalid = 1'b0; start = 1'b0; done_in = 1'b0;
        dump = 1'b0; abort = 1'b0; buffer_size = '0; m_tready = 1'b0;
`ifdef CAPTURE_READOUT_TRIG_MARK_EN
        trig_index = '0;
`endif
        repeat (2) cyc();
        check("rst_srdy", s_tready, 0);
        check("rst_vld", m_tvalid, 0);
        check("rst_last", m_tlast, 0);
        check("rst_data", m_tdata, 0);
        check("rst_cnt", fill_count, 0);
        check("rst_wrap", wrapped, 0);
        check("rst_busy", busy, 0);
        check("rst_hold", holding, 0);
        reset = 1'b1;
        cyc();

        fill(8, 5, 1'b1, 'h10, 1'b0, 1'b0);
        dump_check(100, 2);

        fill(8, 11, 1'b1, 0, 1'b0, 1'b1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("start_in_hold", holding, 1);
        check("start_in_hold_cnt", fill_count, 8);
        dump_check(100, 5);

        fill(8, 8, 1'b0, 0, 1'b1, 1'b0);
        dump_check(50, $urandom_range(0, 9));

        fill(8, 0, 1'b0, 0, 1'b0, 1'b0);
        dump_check(100, 0);

        fill(8, 8, 1'b0, 0, 1'b0, 1'b0);
        dump = 1'b1;
        cyc();
        dump = 1'b0;
        m_tready = 1'b1;
        hs  = 0;
        cnt = 0;
        while (hs < 3 && cnt < 50) begin
            if (m_tvalid) begin
                check("abort_pre_data", m_tdata, model_q[hs]);
                hs++;
            end
            cyc();
            cnt++;
        end
        check("abort_hs", hs, 3);
        abort = 1'b1;
        #1;
        check("abort_vld_now", m_tvalid, 0);
        cyc();
        abort    = 1'b0;
        m_tready = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_vld", m_tvalid, 0);
        check("abort_last", m_tlast, 0);
        fill(8, 6, 1'b0, 0, 1'b0, 1'b0);
        dump_check(70, 3);

        buffer_size = 4'd8;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) begin
            s_tvalid = 1'b1;
            s_tdata  = $urandom;
            cyc();
        end
        reset = 1'b0;
        #1;
        check("arst_srdy", s_tready, 0);
        check("arst_busy", busy, 0);
        check("arst_cnt", fill_count, 0);
        check("arst_wrap", wrapped, 0);
        check("arst_vld", m_tvalid, 0);
        check("arst_data", m_tdata, 0);
        check("arst_hold", holding, 0);
        s_tvalid = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();

        for (int r = 0; r < 5; r++) begin
            fill($urandom_range(0, 15), $urandom_range(1, 40), 1'b0, 0, 1'b1, 1'($urandom_range(1)));
            dump_check($urandom_range(30, 100), $urandom_range(0, 15));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
